fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

- Sequences the instruction-fetch PC of the pipelined core and replaces the free-running PC increment.
- Each cycle it chooses the next PC from four sources: reset vector, branch/jump redirect, hold (stall) or increment.
- It runs a small boot/run/halt state machine, drives the fetch-valid and IF/ID flush signals, and keeps a saturating count of issued fetches.
- It sits between the decode/execute hazard and branch logic and the instruction memory address port.

## Interface
- PC_W, 5, PC width in bits; the PC wraps modulo 2^PC_W.
- RESET_PC, 0, PC loaded on reset.
- CNT_W, 16, width of the fetch counter.
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- stall_i  in  1  hazard stall from decode: hold the PC.
- redirect_i  in  1  taken branch or jump from execute.
- redirect_pc_i  in  PC_W  branch or jump target.
- halt_i  in  1  halt instruction decoded.
- resume_i  in  1  leave HALT.
- pc_o  out  PC_W  current fetch address.
- fetch_valid_o  out  1  pc_o is a real fetch.
- flush_o  out  1  one-cycle pulse that kills the IF/ID register.
- state_o  out  2  BOOT=0, RUN=1, HALT=2; value 3 is unused.
- fetch_cnt_o  out  CNT_W  number of issued fetches, saturating.

## Operation
- All outputs are registered.
- Reset values: pc_o=RESET_PC, state=BOOT, fetch_valid_o=0, flush_o=0, fetch_cnt_o=0. rst mid-operation overrides every other input.
- BOOT:
  - Goes to RUN unconditionally on the next edge. pc_o is held.
  - All inputs are ignored.
- RUN, priority redirect > halt > stall > increment:
  - redirect_i: pc_o<=redirect_pc_i, flush_o<=1 for one cycle, stay in RUN. A simultaneous halt_i or stall_i is ignored, because the instruction that raised it is on the wrong path.
  - halt_i: go to HALT with pc_o held and fetch_valid_o<=0.
  - stall_i: pc_o held, fetch_valid_o stays 1.
  - Otherwise: pc_o<=pc_o+1, truncated to PC_W, so all-ones wraps to 0.
- HALT:
  - redirect_i: pc_o<=redirect_pc_i and go to RUN. flush_o stays 0 because nothing valid is in flight.
  - resume_i (without redirect): go to RUN, pc_o unchanged.
  - stall_i and halt_i are ignored.
- fetch_valid_o is 1 exactly when state==RUN.
- fetch_cnt_o increments on every edge where state==RUN, stall_i=0 and redirect_i=0. It saturates at 2^CNT_W-1.

## Timing
- Reset released at edge N:
  - Edge N+1: state=RUN, fetch_valid_o=1, pc_o=RESET_PC.
  - Edge N+2: pc_o=RESET_PC+1.
- Redirect sampled at edge K:
  - pc_o=target and flush_o=1 during cycle K..K+1.
  - flush_o=0 from edge K+1 unless redirect_i is asserted again.
- Back-to-back redirects keep flush_o high on consecutive cycles.
- Halt sampled at edge K: fetch_valid_o=0 from edge K.
- Resume sampled at edge K: fetch_valid_o=1 from edge K, at the held PC.
- Stall has zero latency: the PC holds on the same edge that stall_i is sampled.

## Configuration
- FETCH_SEQ_WRAP_HALT_EN defined:
  - In RUN, an increment from the all-ones PC (no redirect, stall or halt) enters HALT.
  - pc_o stays at all-ones and fetch_valid_o<=0.
  - This catches runaway programs.
- FETCH_SEQ_WRAP_HALT_EN undefined: the PC wraps to 0 and the sequencer stays in RUN.

## Structure
- Package fetch_seq_pkg holds:
  - the state encoding constants (BOOT, RUN, HALT);
  - the default PC_W, RESET_PC and CNT_W.
- One sub-module, fetch_perf_counter: a CNT_W-bit saturating counter with synchronous active-high clear and an increment enable.
- The next-PC mux and the FSM stay in the top module.

## Test plan
- Reset, then 3 free cycles: state BOOT→RUN; pc_o = 0, 0, 1, 2; fetch_valid_o 0→1; fetch_cnt_o=2.
- At pc=4, stall_i for 2 cycles, then released: pc_o holds at 4 for 2 cycles, then 5; fetch_cnt_o does not count the stall cycles.
- At pc=6, redirect_i with target 0x1A together with halt_i: next pc_o=0x1A; flush_o high for exactly 1 cycle; state stays RUN.
- halt_i at pc=9, then resume_i 3 cycles later: fetch_valid_o=0 and pc_o=9 throughout HALT; after resume pc_o=9 with valid, then 10.
- Run to pc=31 and increment:
  - Macro undefined: pc_o=0, still in RUN.
  - Macro defined: state=HALT, pc_o=31, fetch_valid_o=0.
- rst asserted mid-redirect: pc_o=RESET_PC, flush_o=0, state=BOOT and fetch_cnt_o=0 on the next edge. Also check fetch_cnt_o saturation with CNT_W=2 (count stays at 3).

Source files
------------

// File: rtl/fetch_seq_pkg.sv
// Shared state encoding and default sizing for the fetch sequencer.
package fetch_seq_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    localparam int unsigned DEF_PC_W     = 5;
    localparam int unsigned DEF_RESET_PC = 0;
    localparam int unsigned DEF_CNT_W    = 16;

endpackage

// File: rtl/fetch_perf_counter.sv
// Saturating event counter with synchronous clear and increment enable.
module fetch_perf_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (enable && (count != {CNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch PC sequencer: boot/run/halt FSM, next-PC mux, flush and fetch count.
// Optional build macro FETCH_SEQ_WRAP_HALT_EN: halt instead of wrapping past the all-ones PC.
module fetch_sequencer
    import fetch_seq_pkg::*;
#(
    parameter int unsigned PC_W     = DEF_PC_W,
    parameter int unsigned RESET_PC = DEF_RESET_PC,
    parameter int unsigned CNT_W    = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_i,
    input  logic             redirect_i,
    input  logic [PC_W-1:0]  redirect_pc_i,
    input  logic             halt_i,
    input  logic             resume_i,
    output logic [PC_W-1:0]  pc_o,
    output logic             fetch_valid_o,
    output logic             flush_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] fetch_cnt_o
);

    localparam logic [PC_W-1:0] RST_PC = RESET_PC[PC_W-1:0];

    fetch_state_t state;
    logic         count_en;

    assign state_o  = state;
    // Stalled and redirected cycles are not counted as issued fetches.
    assign count_en = (state == RUN) && !stall_i && !redirect_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= BOOT;
            pc_o          <= RST_PC;
            fetch_valid_o <= 1'b0;
            flush_o       <= 1'b0;
        end else begin
            flush_o <= 1'b0;
            case (state)
                BOOT: begin
                    state         <= RUN;
                    fetch_valid_o <= 1'b1;
                end
                RUN: begin
                    if (redirect_i) begin
                        pc_o    <= redirect_pc_i;
                        flush_o <= 1'b1;
                    end else if (halt_i) begin
                        state         <= HALT;
                        fetch_valid_o <= 1'b0;
                    end else if (!stall_i) begin
`ifdef FETCH_SEQ_WRAP_HALT_EN
                        if (pc_o == {PC_W{1'b1}}) begin
                            state         <= HALT;
                            fetch_valid_o <= 1'b0;
                        end else begin
                            pc_o <= pc_o + 1'b1;
                        end
`else
                        pc_o <= pc_o + 1'b1;
`endif
                    end
                end
                HALT: begin
                    // Nothing valid is in flight here, so a redirect needs no flush.
                    if (redirect_i) begin
                        pc_o          <= redirect_pc_i;
                        state         <= RUN;
                        fetch_valid_o <= 1'b1;
                    end else if (resume_i) begin
                        state         <= RUN;
                        fetch_valid_o <= 1'b1;
                    end
                end
                default: begin
                    state         <= BOOT;
                    fetch_valid_o <= 1'b0;
                end
            endcase
        end
    end

    fetch_perf_counter #(.CNT_W(CNT_W)) u_perf (
        .clk    (clk),
        .clear  (rst),
        .enable (count_en),
        .count  (fetch_cnt_o)
    );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench: directed test-plan sequence plus random traffic against a reference model.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_i = 1'b0, redirect_i = 1'b0, halt_i = 1'b0, resume_i = 1'b0;
    logic [4:0]  redirect_pc_i = '0;

    logic [4:0]  pc_o, pc_s;
    logic        fv_o, fv_s, fl_o, fl_s;
    logic [1:0]  st_o, st_s;
    logic [15:0] cnt_o;
    logic [1:0]  cnt_s;

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .redirect_i(redirect_i),
        .redirect_pc_i(redirect_pc_i), .halt_i(halt_i), .resume_i(resume_i),
        .pc_o(pc_o), .fetch_valid_o(fv_o), .flush_o(fl_o), .state_o(st_o),
        .fetch_cnt_o(cnt_o)
    );

    fetch_sequencer #(.CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .stall_i(stall_i), .redirect_i(redirect_i),
        .redirect_pc_i(redirect_pc_i), .halt_i(halt_i), .resume_i(resume_i),
        .pc_o(pc_s), .fetch_valid_o(fv_s), .flush_o(fl_s), .state_o(st_s),
        .fetch_cnt_o(cnt_s)
    );

    typedef struct {
        int pc; int valid; int flush; int state; int cnt; int cnt_sat;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    bit   done  = 0;

    // Reference model: state 0=boot, 1=run, 2=halt; count is total issued fetches.
    int m_state = 0, m_pc = 0, m_flush = 0, m_issued = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit st, input bit rd, input int rp, input bit hl,
                        input bit rs, input bit r);
        exp_t e;
        @(posedge clk);
        #2;
        stall_i = st; redirect_i = rd; redirect_pc_i = 5'(rp);
        halt_i = hl; resume_i = rs; rst = r;
        m_flush = 0;
        if (r) begin
            m_state = 0; m_pc = 0; m_issued = 0;
        end else if (m_state == 0) begin
            m_state = 1;
        end else if (m_state == 1) begin
            if (!st && !rd) m_issued++;
            if (rd) begin
                m_pc = rp % 32; m_flush = 1;
            end else if (hl) begin
                m_state = 2;
            end else if (!st) begin
`ifdef FETCH_SEQ_WRAP_HALT_EN
                if (m_pc == 31) m_state = 2;
                else m_pc = m_pc + 1;
`else
                m_pc = (m_pc + 1) % 32;
`endif
            end
        end else begin
            if (rd) begin
                m_pc = rp % 32; m_state = 1;
            end else if (rs) begin
                m_state = 1;
            end
        end
        e.pc = m_pc; e.valid = (m_state == 1); e.flush = m_flush; e.state = m_state;
        e.cnt = (m_issued > 65535) ? 65535 : m_issued;
        e.cnt_sat = (m_issued > 3) ? 3 : m_issued;
        q.push_back(e);
    endtask

    // Monitor: outputs are presented every cycle once an expectation exists.
    initial begin
        exp_t e;
        while (!done) begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("pc", int'(pc_o), e.pc);
                chk("fetch_valid", int'(fv_o), e.valid);
                chk("flush", int'(fl_o), e.flush);
                chk("state", int'(st_o), e.state);
                chk("fetch_cnt", int'(cnt_o), e.cnt);
                chk("pc_sat_inst", int'(pc_s), e.pc);
                chk("valid_sat_inst", int'(fv_s), e.valid);
                chk("flush_sat_inst", int'(fl_s), e.flush);
                chk("state_sat_inst", int'(st_s), e.state);
                chk("fetch_cnt_sat", int'(cnt_s), e.cnt_sat);
            end
        end
    end

    initial begin
        // Reset, then free cycles: pc 0,0,1,2 and count 2.
        step(0,0,0,0,0,1); step(0,0,0,0,0,1);
        repeat (5) step(0,0,0,0,0,0);
        // At pc=4: stall two cycles, then release.
        step(1,0,0,0,0,0); step(1,0,0,0,0,0); step(0,0,0,0,0,0);
        step(0,0,0,0,0,0);
        // At pc=6: redirect to 0x1A together with halt.
        step(0,1,'h1A,1,0,0);
        step(0,0,0,0,0,0);
        // Back-to-back redirects, landing on pc=9, then halt there.
        step(0,1,8,0,0,0); step(0,1,9,0,0,0);
        step(0,0,0,1,0,0);
        step(1,0,0,1,0,0); step(0,0,0,0,0,0); step(0,0,0,0,0,0);
        step(0,0,0,0,1,0);
        step(0,0,0,0,0,0); step(0,0,0,0,0,0);
        // Run up to the all-ones PC and past it.
        step(0,1,29,0,0,0);
        repeat (4) step(0,0,0,0,0,0);
        step(0,0,0,0,1,0); step(0,0,0,0,0,0);
        // Reset while a redirect is presented.
        step(0,1,17,0,0,1);
        step(0,0,0,0,0,0); step(0,0,0,0,0,0);
        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(3) == 0, $urandom_range(7) == 0, $urandom_range(31),
                 $urandom_range(11) == 0, $urandom_range(3) == 0, $urandom_range(49) == 0);
        end
        step(0,0,0,0,0,0);
        @(posedge clk); @(posedge clk); #3;
        done = 1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
